// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU op encoding and the ID/EX payload.
package riscv_pkg;

  typedef enum logic [4:0] {
    ALU_NOP    = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_SLL    = 5'd3,
    ALU_SLT    = 5'd4,
    ALU_SLTU   = 5'd5,
    ALU_XOR    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SRA    = 5'd8,
    ALU_OR     = 5'd9,
    ALU_AND    = 5'd10,
    ALU_LUI    = 5'd11,
    ALU_MUL    = 5'd12,
    ALU_MULH   = 5'd13,
    ALU_MULHSU = 5'd14,
    ALU_MULHU  = 5'd15,
    ALU_DIV    = 5'd16,
    ALU_DIVU   = 5'd17,
    ALU_REM    = 5'd18,
    ALU_REMU   = 5'd19
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic [4:0]  alu_op;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side handshake, EX-side outputs, MEM forwarding.
interface id_ex_if;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic        id_use_imm;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write;
  logic [4:0]  id_alu_op;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [4:0]  alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write;
  logic [31:0] mem_result;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr,
    output id_rs1_data, id_rs2_data, id_imm,
    output id_use_imm, id_rd_addr, id_reg_write,
    output id_alu_op, flush, ex_ready,
    output mem_rd_addr, mem_reg_write, mem_result,
    input  id_ready, ex_valid, alu_in1, alu_in2,
    input  alu_op, ex_rd_addr, ex_reg_write
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr,
    input  id_rs1_data, id_rs2_data, id_imm,
    input  id_use_imm, id_rd_addr, id_reg_write,
    input  id_alu_op, flush, ex_ready,
    input  mem_rd_addr, mem_reg_write, mem_result,
    output id_ready, ex_valid, alu_in1, alu_in2,
    output alu_op, ex_rd_addr, ex_reg_write
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// EX/MEM -> operand forwarding compare-and-select for one source register.
module fwd_mux #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        mem_reg_write_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic [31:0] mem_result_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [31:0] rs_data_i,
  output logic [31:0] data_o,
  output logic        hit_o
);

  // x0 is hardwired zero, so a write to it is never a real producer
  assign hit_o = FWD_EN
              && mem_reg_write_i
              && (mem_rd_addr_i != 5'd0)
              && (mem_rd_addr_i == rs_addr_i);

  assign data_o = hit_o ? mem_result_i : rs_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX one-entry elastic pipeline register with EX/MEM operand forwarding.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);

  id_ex_t q_q, q_d;
  logic   valid_q, valid_d;
  logic   capture;
  logic   hit1, hit2;
  logic [31:0] op1, op2;

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd1 (
    .mem_reg_write_i (bus.mem_reg_write),
    .mem_rd_addr_i   (bus.mem_rd_addr),
    .mem_result_i    (bus.mem_result),
    .rs_addr_i       (q_q.rs1_addr),
    .rs_data_i       (q_q.rs1_data),
    .data_o          (op1),
    .hit_o           (hit1)
  );

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd2 (
    .mem_reg_write_i (bus.mem_reg_write),
    .mem_rd_addr_i   (bus.mem_rd_addr),
    .mem_result_i    (bus.mem_result),
    .rs_addr_i       (q_q.rs2_addr),
    .rs_data_i       (q_q.rs2_data),
    .data_o          (op2),
    .hit_o           (hit2)
  );

  // flush empties the entry, so the stage is free to accept
  assign bus.id_ready = !valid_q || bus.ex_ready || bus.flush;
  assign capture = bus.id_valid && bus.id_ready && !bus.flush;

  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d          = 1'b1;
      q_d.rs1_addr     = bus.id_rs1_addr;
      q_d.rs2_addr     = bus.id_rs2_addr;
      q_d.rs1_data     = bus.id_rs1_data;
      q_d.rs2_data     = bus.id_rs2_data;
      q_d.imm          = bus.id_imm;
      q_d.use_imm      = bus.id_use_imm;
      q_d.rd_addr      = bus.id_rd_addr;
      q_d.reg_write    = bus.id_reg_write;
      q_d.alu_op       = bus.id_alu_op;
    end else if (valid_q && bus.ex_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // absorb the producer's result before it leaves MEM
      if (hit1) q_d.rs1_data = op1;
      if (hit2) q_d.rs2_data = op2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.alu_in1      = op1;
  assign bus.alu_in2      = q_q.use_imm ? q_q.imm : op2;
  assign bus.alu_op       = valid_q ? q_q.alu_op : ALU_NOP;
  assign bus.ex_rd_addr   = q_q.rd_addr;
  assign bus.ex_reg_write = valid_q && q_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus stall/reset sequences.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_ex_if bus ();

  id_ex_stage #(.FWD_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic        uimm;
    logic [4:0]  rda;
    logic        rw;
    logic [4:0]  op;
    logic        fl;
    logic        exr;
    logic [4:0]  mrd;
    logic        mrw;
    logic [31:0] mres;
    logic        e_vld;
    logic [31:0] e_in1;
    logic [31:0] e_in2;
    logic [4:0]  e_op;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid      = v.vld;
    bus.id_rs1_addr   = v.rs1a;
    bus.id_rs2_addr   = v.rs2a;
    bus.id_rs1_data   = v.rs1d;
    bus.id_rs2_data   = v.rs2d;
    bus.id_imm        = v.imm;
    bus.id_use_imm    = v.uimm;
    bus.id_rd_addr    = v.rda;
    bus.id_reg_write  = v.rw;
    bus.id_alu_op     = v.op;
    bus.flush         = v.fl;
    bus.ex_ready      = v.exr;
    bus.mem_rd_addr   = v.mrd;
    bus.mem_reg_write = v.mrw;
    bus.mem_result    = v.mres;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(v.e_vld));
    chk({tag, ".alu_in1"}, bus.alu_in1, v.e_in1);
    chk({tag, ".alu_in2"}, bus.alu_in2, v.e_in2);
    chk({tag, ".alu_op"}, 32'(bus.alu_op), 32'(v.e_op));
    chk({tag, ".ex_rd"}, 32'(bus.ex_rd_addr), 32'(v.e_rd));
    chk({tag, ".ex_rw"}, 32'(bus.ex_reg_write), 32'(v.e_rw));
    chk({tag, ".id_ready"}, 32'(bus.id_ready), 32'(v.e_rdy));
  endtask

  vec_t idle;

  initial begin
    checks = 0;
    errors = 0;
    idle = '{1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0,
             5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0,
             1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1};

    // pass-through ADD
    vecs[0] = '{1'b1, 5'd5, 5'd6, 32'd10, 32'd20, 32'd0, 1'b0, 5'd3, 1'b1,
                5'd1, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0,
                1'b1, 32'd10, 32'd20, 5'd1, 5'd3, 1'b1, 1'b1};
    // back-to-back, rs1 forwarded, imm overrides rs2
    vecs[1] = '{1'b1, 5'd7, 5'd8, 32'd100, 32'd200, 32'hFFFF_FFF0, 1'b1,
                5'd4, 1'b1, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF,
                1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 5'd2, 5'd4, 1'b1, 1'b1};
    // x0 source with mem_rd_addr 0: no forwarding
    vecs[2] = '{1'b1, 5'd0, 5'd9, 32'd55, 32'd66, 32'd0, 1'b0, 5'd0, 1'b0,
                5'd3, 1'b0, 1'b1, 5'd0, 1'b1, 32'hDEAD_BEEF,
                1'b1, 32'd55, 32'd66, 5'd3, 5'd0, 1'b0, 1'b1};
    // drain to empty
    vecs[3] = '{1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0,
                1'b0, 32'd55, 32'd66, 5'd0, 5'd0, 1'b0, 1'b1};
    // capture while consumer stalls
    vecs[4] = '{1'b1, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 5'd5, 1'b1,
                5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0,
                1'b1, 32'd1, 32'd2, 5'd4, 5'd5, 1'b1, 1'b0};
    // flush with incoming instruction
    vecs[5] = '{1'b1, 5'd9, 5'd9, 32'd999, 32'd999, 32'd0, 1'b0, 5'd6, 1'b1,
                5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0,
                1'b0, 32'd1, 32'd2, 5'd0, 5'd5, 1'b0, 1'b1};

    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(negedge clk);
    chk_all("reset", idle);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      if (i == 5) begin
        #1;
        chk("flush.id_ready_now", 32'(bus.id_ready), 32'd1);
      end
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // stall three cycles, forwarding match only in the first
    drive(idle);
    bus.id_valid     = 1'b1;
    bus.id_rs1_addr  = 5'd7;
    bus.id_rs2_addr  = 5'd6;
    bus.id_rs1_data  = 32'd11;
    bus.id_rs2_data  = 32'd22;
    bus.id_alu_op    = 5'd1;
    bus.ex_ready     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("stall.ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("stall.in1_pre", bus.alu_in1, 32'd11);
    bus.id_rs1_data   = 32'd77;
    bus.mem_rd_addr   = 5'd7;
    bus.mem_reg_write = 1'b1;
    bus.mem_result    = 32'hDEAD_BEEF;
    #1;
    chk("stall.c1.in1", bus.alu_in1, 32'hDEAD_BEEF);
    chk("stall.c1.id_ready", 32'(bus.id_ready), 32'd0);
    for (int c = 2; c <= 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.mem_reg_write = 1'b0;
      bus.mem_result    = 32'h1234_5678;
      #1;
      chk($sformatf("stall.c%0d.in1", c), bus.alu_in1, 32'hDEAD_BEEF);
      chk($sformatf("stall.c%0d.in2", c), bus.alu_in2, 32'd22);
      chk($sformatf("stall.c%0d.id_ready", c), 32'(bus.id_ready), 32'd0);
      chk($sformatf("stall.c%0d.alu_op", c), 32'(bus.alu_op), 32'd1);
    end

    // reset asserted mid-stall
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid", idle);

    @(negedge clk);
    rst_n = 1'b1;
    drive(vecs[0]);
    @(posedge clk);
    @(negedge clk);
    chk_all("resume", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
